// File: rtl/seq_fixed_point_normalize_if.sv
// Handshake bundle for the fixed-point normalizer: input word channel and result channel.
interface seq_fixed_point_normalize_if #(
  parameter int W  = 16,
  parameter int WM = 8,
  parameter int WE = 6
);
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  i_data;
  logic          o_valid;
  logic          o_ready;
  logic [WM-1:0] o_mant;
  logic [WE-1:0] o_exp;
  logic          o_zero;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_mant, o_exp, o_zero
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_mant, o_exp, o_zero
  );
endinterface

// File: rtl/seq_fixed_point_normalize.sv
// Iterative normalizer: turns a signed Q(WII.WIF) word into mantissa/exponent,
// shifting left one bit per clock, then rounding to WM bits.
module seq_fixed_point_normalize #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WM    = 8,
  parameter int WE    = 6,
  parameter int ROUND = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  seq_fixed_point_normalize_if.slave  bus
);
  localparam int W = WII + WIF;
  localparam logic [WM-1:0]        MANT_MIN  = {1'b1, {(WM-1){1'b0}}};
  localparam logic [WM-1:0]        MANT_HALF = MANT_MIN >> 1;
  localparam logic signed [WE-1:0] E_ONE     = WE'(1);
  localparam logic signed [WE-1:0] E_INIT    = WE'(WII - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, RND, HOLD} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         w_q, w_d;
  logic signed [WE-1:0] e_q, e_d;
  logic [WM-1:0]        mant_q, mant_d;
  logic signed [WE-1:0] exp_q, exp_d;
  logic                 zero_q, zero_d;

  logic [WM-1:0] m_trunc;
  logic [WM-1:0] m_round;
  logic          round_bit;
  logic          carry;

  // A full-width mantissa has no bits below it, so there is nothing to round.
  generate
    if (WM == W) begin : g_full
      assign m_trunc   = w_q;
      assign round_bit = 1'b0;
    end else begin : g_part
      assign m_trunc   = w_q[W-1 -: WM];
      assign round_bit = (ROUND != 0) ? w_q[W-WM-1] : 1'b0;
    end
  endgenerate

  // Only a positive word can round up into the sign bit; a normalized negative
  // word has a zero below its sign, so its increment always fits.
  assign m_round = m_trunc + WM'(round_bit);
  assign carry   = round_bit && !w_q[W-1] && (m_round == MANT_MIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      w_q     <= '0;
      e_q     <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      e_q     <= e_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    e_d     = e_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          w_d     = bus.i_data;
          e_d     = E_INIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if ((w_q == '0) || (w_q[W-1] != w_q[W-2])) begin
          state_d = RND;
        end else begin
          w_d = w_q << 1;
          e_d = e_q - E_ONE;
        end
      end
      RND: begin
        if (w_q == '0) begin
          mant_d = '0;
          exp_d  = '0;
          zero_d = 1'b1;
        end else if (carry) begin
          mant_d = MANT_HALF;
          exp_d  = e_q + E_ONE;
          zero_d = 1'b0;
        end else begin
          mant_d = m_round;
          exp_d  = e_q;
          zero_d = 1'b0;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.i_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == HOLD);
  assign bus.o_mant  = mant_q;
  assign bus.o_exp   = exp_q;
  assign bus.o_zero  = zero_q;
endmodule
